// File: rtl/ready_list_mp.sv
// Multi-priority ready list: one circular doubly-linked TID list per priority,
// serving insert/remove/round-robin get/query through a req/ready/done handshake.
module ready_list_mp #(
    parameter int NTASK = 64,
    parameter int NPRI  = 8,
    localparam int TIDW = $clog2(NTASK),
    localparam int PRIW = $clog2(NPRI)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_i,
    input  logic [2:0]      op_i,
    input  logic [TIDW-1:0] tid_i,
    input  logic [PRIW-1:0] pri_i,
    output logic            ready_o,
    output logic            done_o,
    output logic [1:0]      err_o,
    output logic [TIDW-1:0] tid_o,
    output logic [PRIW-1:0] pri_o,
    output logic [TIDW-1:0] nxt_o,
    output logic [TIDW-1:0] prv_o,
    output logic            inlist_o,
    output logic [NPRI-1:0] nonempty_o,
    output logic [TIDW:0]   count_o
);

    localparam logic [2:0] OP_INS = 3'd0;
    localparam logic [2:0] OP_REM = 3'd1;
    localparam logic [2:0] OP_PRI = 3'd2;
    localparam logic [2:0] OP_ANY = 3'd3;
    localparam logic [2:0] OP_QRY = 3'd4;
    localparam logic [TIDW:0] CNT_ONE = (TIDW+1)'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_INS1, S_INS2, S_INS3, S_REM1, S_REM2, S_REM3, S_GET1, S_QRY1, S_DONE
    } state_t;

    state_t state, state_d;

    logic [TIDW-1:0] nxt  [NTASK];
    logic [TIDW-1:0] prv  [NTASK];
    logic [PRIW-1:0] tpri [NTASK];
    logic [TIDW-1:0] head [NPRI];
    logic [NTASK-1:0] in_list;
    logic [NPRI-1:0]  headv;
    logic [TIDW:0]    count;

    logic [TIDW-1:0] tid_q, tail_q, n_q, pv_q;
    logic [PRIW-1:0] pri_q, rem_pri;
    logic            accept;
    logic [1:0]      acc_err;

    function automatic logic [PRIW-1:0] hi_pri(input logic [NPRI-1:0] v);
        logic [PRIW-1:0] r;
        r = '0;
        for (int p = 0; p < NPRI; p++)
            if (v[p]) r = PRIW'(p);
        return r;
    endfunction

    assign nonempty_o = headv;
    assign count_o    = count;
    assign rem_pri    = tpri[tid_q];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= S_IDLE;
        else         state <= state_d;
    end

    // Errors are decided at acceptance so they finish in a single cycle.
    always_comb begin
        ready_o = (state == S_IDLE) || (state == S_DONE);
        done_o  = (state == S_DONE);
        accept  = req_i && ready_o;
        acc_err = 2'd0;
        case (op_i)
            OP_INS:  if (in_list[tid_i])  acc_err = 2'd1;
            OP_REM:  if (!in_list[tid_i]) acc_err = 2'd2;
            OP_PRI:  if (!headv[pri_i])   acc_err = 2'd3;
            OP_ANY:  if (headv == '0)     acc_err = 2'd3;
            OP_QRY:  acc_err = 2'd0;
            default: acc_err = 2'd3;
        endcase
        state_d = state;
        case (state)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (acc_err != 2'd0) state_d = S_DONE;
                    else begin
                        case (op_i)
                            OP_INS:  state_d = S_INS1;
                            OP_REM:  state_d = S_REM1;
                            OP_QRY:  state_d = S_QRY1;
                            default: state_d = S_GET1;
                        endcase
                    end
                end
            end
            S_INS1:  state_d = headv[pri_q] ? S_INS2 : S_DONE;
            S_INS2:  state_d = S_INS3;
            S_INS3:  state_d = S_DONE;
            S_REM1:  state_d = (nxt[tid_q] == tid_q) ? S_DONE : S_REM2;
            S_REM2:  state_d = S_REM3;
            S_REM3:  state_d = S_DONE;
            S_GET1:  state_d = S_DONE;
            S_QRY1:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Link storage and operand registers carry no reset; every entry is written before use.
    always_ff @(posedge clk_i) begin
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    tid_q <= tid_i;
                    pri_q <= (op_i == OP_ANY) ? hi_pri(headv) : pri_i;
                end
            end
            S_INS1: begin
                if (!headv[pri_q]) begin
                    head[pri_q] <= tid_q;
                    nxt[tid_q]  <= tid_q;
                    prv[tid_q]  <= tid_q;
                    tpri[tid_q] <= pri_q;
                end else begin
                    tail_q <= prv[head[pri_q]];
                end
            end
            S_INS2: begin
                nxt[tail_q]      <= tid_q;
                prv[head[pri_q]] <= tid_q;
            end
            S_INS3: begin
                nxt[tid_q]  <= head[pri_q];
                prv[tid_q]  <= tail_q;
                tpri[tid_q] <= pri_q;
            end
            S_REM1: begin
                pri_q <= rem_pri;
                n_q   <= nxt[tid_q];
                pv_q  <= prv[tid_q];
            end
            S_REM2: begin
                prv[n_q]  <= pv_q;
                nxt[pv_q] <= n_q;
            end
            S_REM3: if (head[pri_q] == tid_q) head[pri_q] <= n_q;
            S_GET1: head[pri_q] <= nxt[head[pri_q]];
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            in_list  <= '0;
            headv    <= '0;
            count    <= '0;
            err_o    <= 2'd0;
            tid_o    <= '1;
            pri_o    <= '0;
            nxt_o    <= '1;
            prv_o    <= '1;
            inlist_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept && acc_err != 2'd0) begin
                        err_o <= acc_err;
                        tid_o <= '1;
                    end
                end
                S_INS1: begin
                    if (!headv[pri_q]) begin
                        headv[pri_q]   <= 1'b1;
                        in_list[tid_q] <= 1'b1;
                        count          <= count + CNT_ONE;
                        err_o          <= 2'd0;
                        tid_o          <= tid_q;
                        pri_o          <= pri_q;
                    end
                end
                S_INS3: begin
                    in_list[tid_q] <= 1'b1;
                    count          <= count + CNT_ONE;
                    err_o          <= 2'd0;
                    tid_o          <= tid_q;
                    pri_o          <= pri_q;
                end
                S_REM1: begin
                    if (nxt[tid_q] == tid_q) begin
                        headv[rem_pri] <= 1'b0;
                        in_list[tid_q] <= 1'b0;
                        count          <= count - CNT_ONE;
                        err_o          <= 2'd0;
                        tid_o          <= tid_q;
                        pri_o          <= rem_pri;
                    end
                end
                S_REM3: begin
                    in_list[tid_q] <= 1'b0;
                    count          <= count - CNT_ONE;
                    err_o          <= 2'd0;
                    tid_o          <= tid_q;
                    pri_o          <= pri_q;
                end
                S_GET1: begin
                    err_o <= 2'd0;
                    tid_o <= head[pri_q];
                    pri_o <= pri_q;
                end
                S_QRY1: begin
                    err_o    <= 2'd0;
                    tid_o    <= tid_q;
                    pri_o    <= tpri[tid_q];
                    inlist_o <= in_list[tid_q];
                    nxt_o    <= in_list[tid_q] ? nxt[tid_q] : '1;
                    prv_o    <= in_list[tid_q] ? prv[tid_q] : '1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ready_list_mp.sv
// Scoreboard bench for ready_list_mp: stimulus queues expected responses,
// a negedge monitor pops and compares them on each done_o pulse.
module tb_ready_list_mp;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       req;
    logic [2:0] op;
    logic [5:0] tid;
    logic [2:0] pri;
    logic       ready_o, done_o, inlist_o;
    logic [1:0] err_o;
    logic [5:0] tid_o, nxt_o, prv_o;
    logic [2:0] pri_o;
    logic [7:0] nonempty_o;
    logic [6:0] count_o;

    always #5 clk = ~clk;

    ready_list_mp #(.NTASK(64), .NPRI(8)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .op_i(op), .tid_i(tid), .pri_i(pri),
        .ready_o(ready_o), .done_o(done_o), .err_o(err_o), .tid_o(tid_o), .pri_o(pri_o),
        .nxt_o(nxt_o), .prv_o(prv_o), .inlist_o(inlist_o),
        .nonempty_o(nonempty_o), .count_o(count_o)
    );

    typedef struct {
        int id; int c0; int lat; int err;
        bit ct; int tid; bit cp; int pri;
        bit cq; int inl; int nx; int pv;
        int cnt; int ne;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int ntest = 0;
    int nfail = 0;
    int cyc = 0;
    int nid = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int id, input string f, input int act, input int expv);
        ntest++;
        if (act != expv) begin
            nfail++;
            $display("FAIL cmd%0d.%s actual=%0h expected=%0h", id, f, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst_ni && done_o) begin
            if (q.size() == 0) begin
                ntest++;
                nfail++;
                $display("FAIL unexpected_done actual=1 expected=0 at cycle %0d", cyc);
            end else begin
                me = q.pop_front();
                chk(me.id, "latency", cyc - me.c0, me.lat);
                chk(me.id, "err", int'(err_o), me.err);
                if (me.ct) chk(me.id, "tid", int'(tid_o), me.tid);
                if (me.cp) chk(me.id, "pri", int'(pri_o), me.pri);
                if (me.cq) begin
                    chk(me.id, "inlist", int'(inlist_o), me.inl);
                    chk(me.id, "nxt", int'(nxt_o), me.nx);
                    chk(me.id, "prv", int'(prv_o), me.pv);
                end
                chk(me.id, "count", int'(count_o), me.cnt);
                chk(me.id, "nonempty", int'(nonempty_o), me.ne);
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [5:0] t, input logic [2:0] p,
                         input exp_t e, input bit push);
        int w;
        w = 0;
        while (!ready_o && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!ready_o) begin
            ntest++;
            nfail++;
            $display("FAIL ready_timeout actual=0 expected=1 cmd%0d", nid);
            return;
        end
        e.id = nid;
        nid++;
        e.c0 = cyc;
        if (push) q.push_back(e);
        req = 1'b1; op = o; tid = t; pri = p;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic ins_ok(input int t, input int p, input int lat, input int cnt, input int ne);
        exp_t e;
        e = '{default: 0};
        e.lat = lat; e.cnt = cnt; e.ne = ne;
        issue(3'd0, 6'(t), 3'(p), e, 1'b1);
    endtask

    task automatic err_cmd(input int o, input int t, input int p, input int er,
                           input int cnt, input int ne);
        exp_t e;
        e = '{default: 0};
        e.lat = 1; e.err = er; e.ct = 1'b1; e.tid = 'h3F; e.cnt = cnt; e.ne = ne;
        issue(3'(o), 6'(t), 3'(p), e, 1'b1);
    endtask

    task automatic rem_ok(input int t, input int ep, input int lat, input int cnt, input int ne);
        exp_t e;
        e = '{default: 0};
        e.lat = lat; e.ct = 1'b1; e.tid = t; e.cp = 1'b1; e.pri = ep; e.cnt = cnt; e.ne = ne;
        issue(3'd1, 6'(t), 3'd0, e, 1'b1);
    endtask

    task automatic get(input int o, input int p, input int et, input int ep,
                       input int cnt, input int ne);
        exp_t e;
        e = '{default: 0};
        e.lat = 2; e.ct = 1'b1; e.tid = et; e.cp = 1'b1; e.pri = ep; e.cnt = cnt; e.ne = ne;
        issue(3'(o), 6'd0, 3'(p), e, 1'b1);
    endtask

    task automatic qry(input int t, input int inl, input int ep, input int nx, input int pv,
                       input int cnt, input int ne);
        exp_t e;
        e = '{default: 0};
        e.lat = 2; e.cp = 1'b1; e.pri = ep; e.cq = 1'b1; e.inl = inl; e.nx = nx; e.pv = pv;
        e.cnt = cnt; e.ne = ne;
        issue(3'd4, 6'(t), 3'd0, e, 1'b1);
    endtask

    initial begin
        exp_t dummy;
        int w;
        rst_ni = 1'b0; req = 1'b0; op = 3'd0; tid = 6'd0; pri = 3'd0;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        chk(0, "rst_ready", int'(ready_o), 1);
        chk(0, "rst_done", int'(done_o), 0);
        chk(0, "rst_err", int'(err_o), 0);
        chk(0, "rst_tid", int'(tid_o), 'h3F);
        chk(0, "rst_nxt", int'(nxt_o), 'h3F);
        chk(0, "rst_prv", int'(prv_o), 'h3F);
        chk(0, "rst_pri", int'(pri_o), 0);
        chk(0, "rst_inlist", int'(inlist_o), 0);
        chk(0, "rst_nonempty", int'(nonempty_o), 0);
        chk(0, "rst_count", int'(count_o), 0);

        ins_ok(5, 3, 2, 1, 'h08);
        err_cmd(0, 5, 3, 1, 1, 'h08);
        rem_ok(5, 3, 2, 0, 'h00);

        ins_ok(7, 1, 2, 1, 'h02);
        ins_ok(20, 6, 2, 2, 'h42);
        get(3, 0, 20, 6, 2, 'h42);
        rem_ok(20, 6, 2, 1, 'h02);
        get(3, 0, 7, 1, 1, 'h02);

        ins_ok(5, 3, 2, 2, 'h0A);
        ins_ok(9, 3, 4, 3, 'h0A);
        ins_ok(12, 3, 4, 4, 'h0A);
        get(2, 3, 5, 3, 4, 'h0A);
        get(2, 3, 9, 3, 4, 'h0A);
        get(2, 3, 12, 3, 4, 'h0A);
        get(2, 3, 5, 3, 4, 'h0A);

        rem_ok(9, 3, 4, 3, 'h0A);
        qry(5, 1, 3, 12, 12, 3, 'h0A);
        qry(9, 0, 3, 'h3F, 'h3F, 3, 'h0A);
        get(2, 3, 12, 3, 3, 'h0A);
        rem_ok(5, 3, 4, 2, 'h0A);
        get(2, 3, 12, 3, 2, 'h0A);

        err_cmd(2, 0, 2, 3, 2, 'h0A);
        err_cmd(1, 30, 0, 2, 2, 'h0A);
        err_cmd(6, 0, 0, 3, 2, 'h0A);

        ins_ok(13, 3, 4, 3, 'h0A);
        dummy = '{default: 0};
        issue(3'd1, 6'd12, 3'd0, dummy, 1'b0);
        @(negedge clk);
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        chk(0, "abort_ready", int'(ready_o), 1);
        chk(0, "abort_done", int'(done_o), 0);
        chk(0, "abort_count", int'(count_o), 0);
        chk(0, "abort_nonempty", int'(nonempty_o), 0);
        err_cmd(3, 0, 0, 3, 0, 'h00);

        w = 0;
        while (q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (q.size() != 0) begin
            ntest++;
            nfail++;
            $display("FAIL drain_timeout actual=%0d pending expected=0", q.size());
        end
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
